// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and constants for the push-button ALU command sequencer.
package alu_cmd_sequencer_pkg;

   localparam int unsigned OP_W     = 4;
   localparam int unsigned OPCNT_W  = 8;
   localparam int unsigned ASEL_W   = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_EXEC,
      ST_COMMIT,
      ST_RELEASE
   } state_e;

   localparam logic [OP_W-1:0] OP_COPY_Y_TO_A = 4'd13;
   localparam logic [OP_W-1:0] OP_SWAP        = 4'd14;
   localparam logic [OP_W-1:0] OP_LOAD_A      = 4'd15;

   localparam logic [ASEL_W-1:0] ASEL_Y  = 2'b00;
   localparam logic [ASEL_W-1:0] ASEL_SW = 2'b01;
   localparam logic [ASEL_W-1:0] ASEL_B  = 2'b10;

   typedef struct packed {
      logic              wr_y;
      logic              wr_a;
      logic              wr_b;
      logic [ASEL_W-1:0] a_sel;
   } strobes_t;

   // Datapath write strobes for one committed op-code.
   function automatic strobes_t decode_op(input logic [OP_W-1:0] op);
      strobes_t s;
      s = '0;
      case (op)
         OP_COPY_Y_TO_A: begin
            s.wr_a  = 1'b1;
            s.a_sel = ASEL_Y;
         end
         OP_SWAP: begin
            s.wr_a  = 1'b1;
            s.wr_b  = 1'b1;
            s.a_sel = ASEL_B;
         end
         OP_LOAD_A: begin
            s.wr_a  = 1'b1;
            s.a_sel = ASEL_SW;
         end
         default: s.wr_y = 1'b1;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/alu_cmd_sequencer_btn_debouncer.sv
// Two-flop synchronizer plus counter debouncer; emits a one-cycle pulse per accepted press.
module btn_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw_i,
   output logic level_o,
   output logic press_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Level flips only after an unbroken run of disagreeing synchronized samples.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Button-driven command sequencer: latches an op-code per press and issues datapath write strobes.
module alu_cmd_sequencer
   import alu_cmd_sequencer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn_raw,
   input  logic [OP_W-1:0]      op_sel,
   output logic [OP_W-1:0]      op_latched,
   output logic                 wr_y,
   output logic                 wr_a,
   output logic [ASEL_W-1:0]    a_sel,
   output logic                 wr_b,
   output logic                 busy,
   output logic [OPCNT_W-1:0]   op_count
);

   logic btn_level, btn_press;

   btn_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk       (clk),
      .reset     (reset),
      .btn_raw_i (btn_raw),
      .level_o   (btn_level),
      .press_o   (btn_press)
   );

   state_e             state_q, state_d;
   logic [OP_W-1:0]    op_latched_q, op_latched_d;
   logic [OPCNT_W-1:0] op_count_q, op_count_d;
   strobes_t           strb_q, strb_d;
   logic               busy_q, busy_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_latched_q <= '0;
         op_count_q   <= '0;
         strb_q       <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_latched_q <= op_latched_d;
         op_count_q   <= op_count_d;
         strb_q       <= strb_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      op_latched_d = op_latched_q;
      op_count_d   = op_count_q;
      strb_d       = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (btn_press) state_d = ST_LATCH;
         end
         ST_LATCH: begin
            op_latched_d = op_sel;
            state_d      = ST_EXEC;
         end
         // Strobes are registered, so decoding here makes them visible exactly during COMMIT.
         ST_EXEC: begin
            strb_d  = decode_op(op_latched_q);
            state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            op_count_d = op_count_q + OPCNT_W'(1);
            state_d    = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (!btn_level) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   assign op_latched = op_latched_q;
   assign op_count   = op_count_q;
   assign wr_y       = strb_q.wr_y;
   assign wr_a       = strb_q.wr_a;
   assign wr_b       = strb_q.wr_b;
   assign a_sel      = strb_q.a_sel;
   assign busy       = busy_q;

endmodule
